// File: rtl/serial_reg_bridge_pkg.sv
// Shared command codes and FSM state encoding
// for the serial register bridge.
package serial_reg_bridge_pkg;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    RLATCH,
    TX,
    ACK
  } state_t;

endpackage

// File: rtl/serial_reg_bridge_frame_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled,
// pulses expire in the cycle the count reaches TIMEOUT.
module frame_timeout #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || !enable_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  // An accepted byte in the expiry cycle wins over the timeout.
  assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/serial_reg_bridge.sv
// Framed byte-stream parser driving the register bank write bus
// and streaming read data back to the host.
module serial_reg_bridge
  import serial_reg_bridge_pkg::*;
#(
  parameter int unsigned ADRSIZE = 8,
  parameter int unsigned REGSIZE = 32,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [ADRSIZE-1:0] adr,
  output logic [REGSIZE-1:0] bus_wr,
  output logic               wr,
  input  logic [REGSIZE-1:0] bus_rd,
  output logic               err,
  output logic               busy
);

  localparam int unsigned NBYTES = REGSIZE / 8;
  localparam int unsigned BW = $clog2(NBYTES + 1);
  localparam logic [BW-1:0] LAST_B = BW'(NBYTES - 1);

  state_t             state_q;
  logic               rd_q;
  logic [BW-1:0]      bcnt_q;
  logic [REGSIZE-1:0] shift_q;
  logic [ADRSIZE-1:0] adr_q;
  logic [REGSIZE-1:0] bus_wr_q;
  logic               wr_q;
  logic               err_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;

  logic rx_fire;
  logic in_frame;
  logic expire;

  assign rx_ready = (state_q == IDLE) || (state_q == ADDR) ||
                    (state_q == DATA);
  assign rx_fire  = rx_valid && rx_ready;
  assign in_frame = (state_q == ADDR) || (state_q == DATA);

  frame_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (rx_fire),
    .enable_i(in_frame),
    .expire_o(expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_q       <= 1'b0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      adr_q      <= '0;
      bus_wr_q   <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_fire) begin
            if (rx_data == CMD_WR || rx_data == CMD_RD) begin
              rd_q    <= (rx_data == CMD_RD);
              state_q <= ADDR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (rx_fire) begin
            adr_q   <= rx_data[ADRSIZE-1:0];
            bcnt_q  <= '0;
            state_q <= rd_q ? RLATCH : DATA;
          end else if (expire) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (rx_fire) begin
            bus_wr_q <= {bus_wr_q[REGSIZE-9:0], rx_data};
            bcnt_q   <= bcnt_q + BW'(1);
            if (bcnt_q == LAST_B) begin
              wr_q    <= 1'b1;
              state_q <= WRITE;
            end
          end else if (expire) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        WRITE: begin
          tx_data_q  <= ACK_BYTE;
          tx_valid_q <= 1'b1;
          state_q    <= ACK;
        end
        ACK: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        // adr settled last cycle, so the bank mux output is valid now
        RLATCH: begin
          shift_q    <= bus_rd;
          tx_data_q  <= bus_rd[REGSIZE-1 -: 8];
          tx_valid_q <= 1'b1;
          bcnt_q     <= '0;
          state_q    <= TX;
        end
        TX: begin
          if (tx_ready) begin
            bcnt_q <= bcnt_q + BW'(1);
            if (bcnt_q == LAST_B) begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              shift_q   <= {shift_q[REGSIZE-9:0], 8'h00};
              tx_data_q <= shift_q[REGSIZE-9 -: 8];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign adr      = adr_q;
  assign bus_wr   = bus_wr_q;
  assign wr       = wr_q;
  assign err      = err_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != IDLE);

endmodule
